// File: rtl/joy_serial_rx.sv
// Serial receiver for the two-player DB15 joystick adapter: drives load/shift
// pins, samples 32-bit frames and commits them after a stability filter.
module joy_serial_rx #(
  parameter int unsigned CLK_DIV   = 50,
  parameter int unsigned GAP_TICKS = 64,
  parameter int unsigned STABLE    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    CHECK,
    GAP
  } state_t;

  localparam logic [9:0] TICK_LAST = 10'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);
  localparam logic [2:0] STAB_MAX  = 3'(STABLE);

  state_t      state;
  logic [9:0]  tick_cnt;
  logic        tick;
  logic [4:0]  idx;
  logic [7:0]  gap_cnt;
  logic [2:0]  stab;
  logic [2:0]  stab_next;
  logic [31:0] raw;
  logic [31:0] prev;
  logic [1:0]  sync;
  logic        data_s;

  assign tick   = (tick_cnt == TICK_LAST);
  assign data_s = sync[1];

  always_comb begin
    stab_next = 3'd1;
    if (raw == prev) begin
      stab_next = (stab >= STAB_MAX) ? STAB_MAX : stab + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[0], joy_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      stab       <= '0;
      raw        <= '0;
      prev       <= '0;
      joy_clk    <= 1'b1;
      joy_load   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      stab       <= '0;
      raw        <= '0;
      prev       <= '0;
      joy_clk    <= 1'b1;
      joy_load   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Tick counter pauses during the one-clk CHECK so the frame period gains exactly one clk.
      if (state != CHECK) begin
        tick_cnt <= tick ? '0 : tick_cnt + 10'd1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= LOAD;
            joy_load <= 1'b0;
          end
        end
        LOAD: begin
          if (tick) begin
            state    <= SHIFT_LO;
            joy_load <= 1'b1;
            joy_clk  <= 1'b0;
            idx      <= '0;
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            raw[idx] <= ~data_s;
            joy_clk  <= 1'b1;
            state    <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            if (idx == 5'd31) begin
              state <= CHECK;
            end else begin
              idx     <= idx + 5'd1;
              joy_clk <= 1'b0;
              state   <= SHIFT_LO;
            end
          end
        end
        CHECK: begin
          frame_done <= 1'b1;
          stab       <= stab_next;
          prev       <= raw;
          if (stab_next == STAB_MAX) begin
            joystick1 <= raw[15:0];
            joystick2 <= raw[31:16];
          end
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              state    <= LOAD;
              joy_load <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joy_serial_rx.sv
// Bench for joy_serial_rx: shift-register adapter model, frame-history reference
// model, table-driven frame sequences plus hand-written corner cases.
module tb_joy_serial_rx;

  localparam int unsigned STABLE = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        joy_data = 1'b1;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;

  joy_serial_rx #(.CLK_DIV(4), .GAP_TICKS(2), .STABLE(STABLE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .joy_data  (joy_data),
    .joy_clk   (joy_clk),
    .joy_load  (joy_load),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Adapter: latches the frame on load, presents bit 0, advances on each rising shift clock.
  logic [31:0] adapter_frame = '0;
  logic [31:0] latch = '0;
  logic [31:0] sh;
  int          bitk = 0;
  always @(negedge joy_load or posedge joy_clk) begin
    if (!joy_load) begin
      latch    = adapter_frame;
      bitk     = 0;
      joy_data = ~adapter_frame[0];
    end else begin
      if (bitk < 32) bitk++;
      sh       = latch >> bitk;
      joy_data = (bitk < 32) ? ~sh[0] : 1'b1;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: output follows a frame once the last STABLE captured frames agree.
  logic [31:0] hist[$];
  logic [31:0] model_out = '0;

  task automatic model_clear();
    hist.delete();
    model_out = '0;
  endtask

  task automatic model_push(input logic [31:0] f);
    bit same;
    hist.push_back(f);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() >= STABLE) begin
      same = 1'b1;
      for (int k = 0; k < STABLE; k++)
        if (hist[hist.size() - 1 - k] != f) same = 1'b0;
      if (same) model_out = f;
    end
  endtask

  task automatic run_frame(input logic [31:0] f);
    int i;
    adapter_frame = f;
    i = 0;
    while (!frame_done && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("frame_done seen", 32'(frame_done), 32'd1);
    model_push(f);
    chk("joystick1 model", 32'(joystick1), 32'(model_out[15:0]));
    chk("joystick2 model", 32'(joystick2), 32'(model_out[31:16]));
    @(negedge clk);
    chk("frame_done pulse width", 32'(frame_done), 32'd0);
  endtask

  task automatic chk_parked(input string tag);
    chk({tag, " joystick1"}, 32'(joystick1), 32'd0);
    chk({tag, " joystick2"}, 32'(joystick2), 32'd0);
    chk({tag, " joy_clk"}, 32'(joy_clk), 32'd1);
    chk({tag, " joy_load"}, 32'(joy_load), 32'd1);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic restart(input logic [31:0] f);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_parked("restart");
    model_clear();
    adapter_frame = f;
    enable = 1'b1;
  endtask

  task automatic wait_load_low();
    int i;
    i = 0;
    while (joy_load && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("joy_load seen low", 32'(joy_load), 32'd0);
  endtask

  typedef struct {
    logic        restart;
    logic [31:0] frame;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  vec_t        vecs[13];
  int          n;
  int          falls;
  logic        last;
  logic        seen_hi;
  logic [31:0] rf;

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0013, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 32'h0000_0013, 16'h0013, 16'h0000};
    vecs[2]  = '{1'b0, 32'h0000_0013, 16'h0013, 16'h0000};
    vecs[3]  = '{1'b1, 32'hA5A5_0001, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 32'h5A5A_0001, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 32'hA5A5_0001, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 32'h5A5A_0001, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 32'hFFFF_8000, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 32'hFFFF_8000, 16'h8000, 16'hFFFF};
    vecs[9]  = '{1'b0, 32'h1234_5678, 16'h8000, 16'hFFFF};
    vecs[10] = '{1'b0, 32'h1234_5678, 16'h5678, 16'h1234};
    vecs[11] = '{1'b0, 32'h0000_0000, 16'h5678, 16'h1234};
    vecs[12] = '{1'b0, 32'h0000_0000, 16'h0000, 16'h0000};

    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    chk_parked("reset");
    reset_n = 1'b1;
    @(negedge clk);
    model_clear();

    // Pin timing of the first frame after enable.
    adapter_frame = 32'h0000_0013;
    enable = 1'b1;
    wait_load_low();
    n = 0;
    while (!joy_load && n < 100) begin n++; @(negedge clk); end
    chk("load low width", 32'(n), 32'd4);
    for (int p = 0; p < 32; p++) begin
      n = 0;
      while (!joy_clk && n < 100) begin n++; @(negedge clk); end
      chk("shift clk low width", 32'(n), 32'd4);
      if (p < 31) begin
        n = 0;
        while (joy_clk && n < 100) begin n++; @(negedge clk); end
        chk("shift clk high width", 32'(n), 32'd4);
      end
    end

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].restart) restart(vecs[v].frame);
      run_frame(vecs[v].frame);
      chk("table joystick1", 32'(joystick1), 32'(vecs[v].exp1));
      chk("table joystick2", 32'(joystick2), 32'(vecs[v].exp2));
    end

    // Disable in the middle of bit 10.
    run_frame(32'hFFFF_8000);
    run_frame(32'hFFFF_8000);
    chk("pre-disable joystick1", 32'(joystick1), 32'h8000);
    wait_load_low();
    falls = 0;
    last  = joy_clk;
    n     = 0;
    while (falls < 11 && n < 400) begin
      @(negedge clk);
      n++;
      if (last && !joy_clk) falls++;
      last = joy_clk;
    end
    chk("bit 10 reached", 32'(falls), 32'd11);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk_parked("disable");
    model_clear();
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_done) n++;
    end
    chk("no frame_done while disabled", 32'(n), 32'd0);
    adapter_frame = 32'hFFFF_8000;
    enable = 1'b1;
    run_frame(32'hFFFF_8000);
    chk("re-enable 1st frame joystick2", 32'(joystick2), 32'h0000);
    run_frame(32'hFFFF_8000);
    chk("re-enable 2nd frame joystick2", 32'(joystick2), 32'hFFFF);

    // Frame period between successive load falling edges.
    wait_load_low();
    n = 0;
    seen_hi = 1'b0;
    while (n < 400 && !(seen_hi && !joy_load)) begin
      @(negedge clk);
      n++;
      if (joy_load) seen_hi = 1'b1;
    end
    chk("frame period", 32'(n), 32'd269);

    // Random frames, biased towards repeats so commits happen.
    rf = $urandom;
    restart(rf);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) < 3) rf = $urandom;
      run_frame(rf);
    end

    // Asynchronous reset between clock edges during SHIFT_LO.
    run_frame(32'h0F0F_F0F0);
    run_frame(32'h0F0F_F0F0);
    chk("pre-reset joystick1", 32'(joystick1), 32'hF0F0);
    wait_load_low();
    n = 0;
    while (joy_clk && n < 100) begin @(negedge clk); n++; end
    chk("in SHIFT_LO", 32'(joy_clk), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_parked("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    run_frame(32'h0000_0013);
    run_frame(32'h0000_0013);
    chk("post-reset joystick1", 32'(joystick1), 32'h0013);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
